// File: rtl/sisc_mem_pkg.sv
// Shared SISC memory-port definitions: arbiter state encoding, requester IDs and
// default address/data widths.
package sisc_mem_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } mem_state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  localparam int unsigned DEF_AW = 16;
  localparam int unsigned DEF_DW = 32;

endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-port bundle for mem_arb. The slave modport is the arbiter
// view; the master modport is the environment (requesters plus memory) view.
interface mem_arb_if
  import sisc_mem_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
) ();

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_done;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_done;
  logic [DW-1:0] dm_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requests.
// MEM_ARB_RR_EN selects strict round-robin; otherwise dm priority with starvation guard.
module mem_arb_pick
  import sisc_mem_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
  input  logic starve,
  input  logic last_gnt,
  output logic win_id,
  output logic win_valid
);

`ifdef MEM_ARB_RR_EN
  logic unused_starve;
  assign unused_starve = starve;

  always_comb begin
    win_valid = if_req | dm_req;
    win_id    = dm_req ? REQ_DM : REQ_IF;
    if (if_req && dm_req) begin
      win_id = (last_gnt == REQ_IF) ? REQ_DM : REQ_IF;
    end
  end
`else
  logic unused_last;
  assign unused_last = last_gnt;

  always_comb begin
    win_valid = if_req | dm_req;
    win_id    = dm_req ? REQ_DM : REQ_IF;
    // A starved fetch overrides data priority only under contention.
    if (if_req && dm_req) begin
      win_id = starve ? REQ_IF : REQ_DM;
    end
  end
`endif

endmodule

// File: rtl/mem_arb.sv
// Single-port memory arbiter/sequencer: one access at a time, fixed latency count,
// registered grant/done pulses. Optional MEM_ARB_RR_EN selects round-robin arbitration.
module mem_arb
  import sisc_mem_pkg::*;
#(
  parameter int unsigned AW         = DEF_AW,
  parameter int unsigned DW         = DEF_DW,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic      clk,
  input  logic      rst_f,
  mem_arb_if.slave  bus
);

  localparam logic [3:0] LatLast = 4'(MEM_LAT - 1);

  mem_state_e    state_q;
  logic [3:0]    cnt_q;
  logic          win_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          mem_en_q, mem_we_q;
  logic          if_gnt_q, dm_gnt_q, if_done_q, dm_done_q;
  logic [DW-1:0] if_rdata_q, dm_rdata_q;

  logic win_id, win_valid, starve, last_gnt;

`ifdef MEM_ARB_RR_EN
  logic last_q;
  assign starve   = 1'b0;
  assign last_gnt = last_q;
`else
  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);
  logic [3:0] starve_q;
  assign starve   = (starve_q == StarveMax);
  assign last_gnt = REQ_IF;
`endif

  mem_arb_pick u_pick (
    .if_req    (bus.if_req),
    .dm_req    (bus.dm_req),
    .starve    (starve),
    .last_gnt  (last_gnt),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      win_q      <= REQ_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_gnt_q   <= 1'b0;
      dm_gnt_q   <= 1'b0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q     <= REQ_IF;
`else
      starve_q   <= '0;
`endif
    end else begin
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      if_gnt_q  <= 1'b0;
      dm_gnt_q  <= 1'b0;
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_valid) begin
            state_q  <= StIssue;
            win_q    <= win_id;
            we_q     <= (win_id == REQ_DM) && bus.dm_we;
            addr_q   <= (win_id == REQ_DM) ? bus.dm_addr : bus.if_addr;
            wdata_q  <= (win_id == REQ_DM) ? bus.dm_wdata : '0;
            mem_en_q <= 1'b1;
            mem_we_q <= (win_id == REQ_DM) && bus.dm_we;
            if_gnt_q <= (win_id == REQ_IF);
            dm_gnt_q <= (win_id == REQ_DM);
`ifdef MEM_ARB_RR_EN
            last_q   <= win_id;
`else
            if (win_id == REQ_IF) begin
              starve_q <= '0;
            end else if (bus.if_req && !starve) begin
              starve_q <= starve_q + 4'd1;
            end
`endif
          end
        end
        StIssue: begin
          state_q <= StWait;
          cnt_q   <= '0;
        end
        StWait: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LatLast) begin
            state_q <= StDone;
            // Stores leave the requester's read register untouched.
            if (!we_q) begin
              if (win_q == REQ_DM) dm_rdata_q <= bus.mem_rdata;
              else                 if_rdata_q <= bus.mem_rdata;
            end
            if_done_q <= (win_q == REQ_IF);
            dm_done_q <= (win_q == REQ_DM);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_gnt    = if_gnt_q;
  assign bus.dm_gnt    = dm_gnt_q;
  assign bus.if_done   = if_done_q;
  assign bus.dm_done   = dm_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: three instances with MEM_LAT 2, 1 and 15, each with a
// small read-only memory model that presents data only on the exact valid cycle.
module tb_mem_arb;
  import sisc_mem_pkg::*;

  logic clk   = 1'b0;
  logic rst_f = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        if_req_d   [3];
  logic [15:0] if_addr_d  [3];
  logic        dm_req_d   [3];
  logic        dm_we_d    [3];
  logic [15:0] dm_addr_d  [3];
  logic [31:0] dm_wdata_d [3];

  logic [2:0]  if_gnt_w, dm_gnt_w, if_done_w, dm_done_w, mem_en_w, mem_we_w, busy_w;
  logic [15:0] mem_addr_w  [3];
  logic [31:0] mem_wdata_w [3];
  logic [31:0] if_rdata_w  [3];
  logic [31:0] dm_rdata_w  [3];

  function automatic logic [31:0] rd_val(input logic [15:0] a);
    return (a == 16'h0010) ? 32'hDEAD_BEEF : {~a, a};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    mem_arb_if bus ();
    mem_arb #(.MEM_LAT(Lat)) u_dut (
      .clk   (clk),
      .rst_f (rst_f),
      .bus   (bus)
    );
    assign bus.if_req   = if_req_d[g];
    assign bus.if_addr  = if_addr_d[g];
    assign bus.dm_req   = dm_req_d[g];
    assign bus.dm_we    = dm_we_d[g];
    assign bus.dm_addr  = dm_addr_d[g];
    assign bus.dm_wdata = dm_wdata_d[g];
    assign if_gnt_w[g]    = bus.if_gnt;
    assign dm_gnt_w[g]    = bus.dm_gnt;
    assign if_done_w[g]   = bus.if_done;
    assign dm_done_w[g]   = bus.dm_done;
    assign mem_en_w[g]    = bus.mem_en;
    assign mem_we_w[g]    = bus.mem_we;
    assign busy_w[g]      = bus.busy;
    assign mem_addr_w[g]  = bus.mem_addr;
    assign mem_wdata_w[g] = bus.mem_wdata;
    assign if_rdata_w[g]  = bus.if_rdata;
    assign dm_rdata_w[g]  = bus.dm_rdata;

    // age counts cycles since the mem_en cycle; data is valid only at age == Lat.
    int unsigned age = 100;
    logic [15:0] ra  = '0;
    always @(negedge clk) begin
      if (bus.mem_en) begin
        age = 0;
        ra  = bus.mem_addr;
      end else if (age < 100) begin
        age = age + 1;
      end
      bus.mem_rdata = (age == Lat) ? rd_val(ra) : (32'hBAD0_0000 | 32'(age));
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Starts at a negedge with instance g idle; returns at the negedge of cycle lat+3.
  task automatic access(input int g, input int lat, input bit is_dm, input bit we,
                        input logic [15:0] addr, input logic [31:0] wdata, input bit pulse_if);
    if (is_dm) begin
      dm_req_d[g] = 1'b1; dm_we_d[g] = we; dm_addr_d[g] = addr; dm_wdata_d[g] = wdata;
    end else begin
      if_req_d[g] = 1'b1; if_addr_d[g] = addr;
    end
    for (int k = 1; k <= lat + 3; k++) begin
      @(negedge clk);
      if (pulse_if) if_req_d[g] = (k == 1);
      check_eq($sformatf("gnt%0d@%0d", g, k),
               32'(is_dm ? dm_gnt_w[g] : if_gnt_w[g]), 32'(k == 1));
      check_eq($sformatf("other_gnt%0d@%0d", g, k),
               32'(is_dm ? if_gnt_w[g] : dm_gnt_w[g]), 32'd0);
      check_eq($sformatf("done%0d@%0d", g, k),
               32'(is_dm ? dm_done_w[g] : if_done_w[g]), 32'(k == lat + 2));
      check_eq($sformatf("other_done%0d@%0d", g, k),
               32'(is_dm ? if_done_w[g] : dm_done_w[g]), 32'd0);
      check_eq($sformatf("mem_en%0d@%0d", g, k), 32'(mem_en_w[g]), 32'(k == 1));
      check_eq($sformatf("mem_we%0d@%0d", g, k), 32'(mem_we_w[g]), 32'(k == 1 && we));
      check_eq($sformatf("busy%0d@%0d", g, k), 32'(busy_w[g]), 32'(k <= lat + 2));
      if (k <= lat + 2) check_eq($sformatf("mem_addr%0d@%0d", g, k), 32'(mem_addr_w[g]), 32'(addr));
      if (k == 1 && we) check_eq($sformatf("mem_wdata%0d", g), mem_wdata_w[g], wdata);
      if (k == lat + 2) begin
        if (is_dm) dm_req_d[g] = 1'b0;
        else       if_req_d[g] = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, gap, exp;
    for (int g = 0; g < 3; g++) begin
      if_req_d[g] = 1'b0; if_addr_d[g] = '0; dm_req_d[g] = 1'b0;
      dm_we_d[g] = 1'b0; dm_addr_d[g] = '0; dm_wdata_d[g] = '0;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy_w), 32'd0);
    check_eq("rst_gnt", 32'({if_gnt_w, dm_gnt_w}), 32'd0);
    check_eq("rst_done", 32'({if_done_w, dm_done_w}), 32'd0);
    check_eq("rst_mem_strobe", 32'({mem_en_w, mem_we_w}), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr_w[0]), 32'd0);
    check_eq("rst_mem_wdata", mem_wdata_w[0], 32'd0);
    check_eq("rst_if_rdata", if_rdata_w[0], 32'd0);
    check_eq("rst_dm_rdata", dm_rdata_w[0], 32'd0);
    rst_f = 1'b1;
    @(negedge clk);

    // Lone fetch, load, then store that must not disturb dm_rdata.
    access(0, 2, 1'b0, 1'b0, 16'h0010, 32'd0, 1'b0);
    check_eq("fetch_rdata", if_rdata_w[0], 32'hDEAD_BEEF);
    access(0, 2, 1'b1, 1'b0, 16'h0030, 32'd0, 1'b0);
    check_eq("load_rdata", dm_rdata_w[0], 32'hFFCF_0030);
    access(0, 2, 1'b1, 1'b1, 16'h0020, 32'h1234_5678, 1'b0);
    check_eq("store_keeps_dm_rdata", dm_rdata_w[0], 32'hFFCF_0030);
    check_eq("store_keeps_if_rdata", if_rdata_w[0], 32'hDEAD_BEEF);

    // Fetch request pulsed while busy and dropped before IDLE is never granted.
    access(0, 2, 1'b1, 1'b0, 16'h0040, 32'd0, 1'b1);
    check_eq("drop_load_rdata", dm_rdata_w[0], 32'hFFBF_0040);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq($sformatf("drop_if_gnt@%0d", c), 32'(if_gnt_w[0]), 32'd0);
      check_eq($sformatf("drop_if_done@%0d", c), 32'(if_done_w[0]), 32'd0);
      check_eq($sformatf("drop_busy@%0d", c), 32'(busy_w[0]), 32'd0);
    end

    // Contention from a fresh reset: both requests held high.
    rst_f = 1'b0;
    @(negedge clk);
    rst_f = 1'b1;
    if_req_d[0] = 1'b1; if_addr_d[0] = 16'h0050;
    dm_req_d[0] = 1'b1; dm_we_d[0] = 1'b0; dm_addr_d[0] = 16'h0060;
    for (int n = 0; n < 10; n++) begin
      got = -1;
      gap = 0;
      for (int c = 0; c < 20 && got < 0; c++) begin
        @(negedge clk);
        gap = c;
        if (if_gnt_w[0] && dm_gnt_w[0]) got = 2;
        else if (dm_gnt_w[0])           got = 1;
        else if (if_gnt_w[0])           got = 0;
      end
`ifdef MEM_ARB_RR_EN
      exp = (n % 2 == 0) ? 1 : 0;
`else
      exp = (n % 5 == 4) ? 0 : 1;
`endif
      check_eq($sformatf("arb_winner%0d", n), 32'(got), 32'(exp));
      check_eq($sformatf("arb_gap%0d", n), 32'(gap), (n == 0) ? 32'd0 : 32'd4);
    end
    if_req_d[0] = 1'b0;
    dm_req_d[0] = 1'b0;
    got = -1;
    for (int c = 0; c < 20 && got < 0; c++) begin
      @(negedge clk);
      if (!busy_w[0]) got = c;
    end
    check_eq("arb_drain", 32'(got >= 0), 32'd1);
    check_eq("arb_if_rdata", if_rdata_w[0], 32'hFFAF_0050);
    check_eq("arb_dm_rdata", dm_rdata_w[0], 32'hFF9F_0060);

    // Reset in WAIT aborts the access.
    if_req_d[0] = 1'b1; if_addr_d[0] = 16'h0070;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_busy", 32'(busy_w[0]), 32'd1);
    rst_f = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq($sformatf("mid_rst_busy@%0d", c), 32'(busy_w[0]), 32'd0);
      check_eq($sformatf("mid_rst_done@%0d", c), 32'({if_done_w[0], dm_done_w[0]}), 32'd0);
      check_eq($sformatf("mid_rst_mem@%0d", c), 32'({mem_en_w[0], mem_we_w[0]}), 32'd0);
    end
    check_eq("mid_rst_mem_addr", 32'(mem_addr_w[0]), 32'd0);
    check_eq("mid_rst_if_rdata", if_rdata_w[0], 32'd0);
    check_eq("mid_rst_dm_rdata", dm_rdata_w[0], 32'd0);
    if_req_d[0] = 1'b0;
    rst_f = 1'b1;
    @(negedge clk);
    access(0, 2, 1'b0, 1'b0, 16'h0070, 32'd0, 1'b0);
    check_eq("post_rst_rdata", if_rdata_w[0], 32'hFF8F_0070);

    // Latency boundaries.
    access(1, 1, 1'b0, 1'b0, 16'h0010, 32'd0, 1'b0);
    check_eq("lat1_rdata", if_rdata_w[1], 32'hDEAD_BEEF);
    access(2, 15, 1'b0, 1'b0, 16'h0080, 32'd0, 1'b0);
    check_eq("lat15_rdata", if_rdata_w[2], 32'hFF7F_0080);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
